// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle sequencer: FSM states,
// RV32 opcodes, ALU operation classes/codes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R,
    EXEC_I, ALUWB, JAL, JALR, BRANCH, LUI, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ALUOP_ADD, ALUOP_BRANCH, ALUOP_R, ALUOP_I
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SRA = 3'd7;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  // Immediate formats: I, S, B, and J/U sharing one code (the immediate
  // generator tells J from U by opcode).
  localparam logic [1:0] IMM_I  = 2'b00;
  localparam logic [1:0] IMM_S  = 2'b01;
  localparam logic [1:0] IMM_B  = 2'b10;
  localparam logic [1:0] IMM_JU = 2'b11;

  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU-control decode: maps the operation class and funct fields to an ALU code.
module mc_alu_dec
  import mc_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  alu_op_t               alu_op,
  output logic [ALU_CTRL_W-1:0] alu_ctrl
);

  logic [2:0] code;

  // funct7b5 selects sub only for register ops; for shifts it selects sra in
  // both register and immediate forms. xor has no slot and decodes as add.
  always_comb begin
    code = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:    code = ALU_ADD;
      ALUOP_BRANCH: code = funct3[2] ? ALU_SLT : ALU_SUB;
      ALUOP_R, ALUOP_I: begin
        case (funct3)
          3'b000:  code = (alu_op == ALUOP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  code = ALU_SLL;
          3'b010:  code = ALU_SLT;
          3'b011:  code = ALU_SLT;
          3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          default: code = ALU_ADD;
        endcase
      end
      default:      code = ALU_ADD;
    endcase
  end

  assign alu_ctrl = ALU_CTRL_W'(code);

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle RV32 control sequencer with memory-wait timeout.
// Optional feature: define SEQ_TRAP_EN to trap undecodable opcodes and pulse
// illegal; otherwise they return silently to FETCH and illegal stays 0.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int WAIT_MAX   = 15,
  parameter int WAIT_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  bus_err,
  output logic                  illegal
);

  state_t                state, state_next;
  alu_op_t               alu_op;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  mem_state;
  logic                  wait_hit;

  assign mem_state = is_mem_state(state);
  assign wait_hit  = mem_state && !mem_ready &&
                     (wait_cnt == WAIT_CNT_W'(WAIT_MAX - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Consecutive not-ready cycle counter; cleared on completion, timeout or exit.
  always_ff @(posedge clk) begin
    if (reset || !mem_state || mem_ready || wait_hit || (state_next != state))
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
  end

  // Next-state and control outputs; reset forces every output low.
  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    adr_src    = ADR_PC;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    bus_err    = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        if (wait_hit) begin
          bus_err    = 1'b1;
          state_next = FETCH;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_a  = SRC_A_PC;
            alu_src_b  = SRC_B_FOUR;
            result_src = RES_ALU;
            state_next = DECODE;
          end
        end
      end
      DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_BRANCH:        imm_src = IMM_B;
          OP_JAL, OP_AUIPC: imm_src = IMM_JU;
          default:          imm_src = IMM_I;
        endcase
        case (opcode)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_R:              state_next = EXEC_R;
          OP_I:              state_next = EXEC_I;
          OP_JAL:            state_next = JAL;
          OP_JALR:           state_next = JALR;
          OP_BRANCH:         state_next = BRANCH;
          OP_LUI, OP_AUIPC:  state_next = LUI;
`ifdef SEQ_TRAP_EN
          default:           state_next = TRAP;
`else
          default:           state_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_next = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        if (wait_hit) begin
          bus_err    = 1'b1;
          state_next = FETCH;
        end else begin
          mem_req = 1'b1;
          adr_src = ADR_RESULT;
          if (mem_ready) state_next = MEMWB;
        end
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        if (wait_hit) begin
          bus_err    = 1'b1;
          state_next = FETCH;
        end else begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = ADR_RESULT;
          if (mem_ready) state_next = FETCH;
        end
      end
      EXEC_R: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALUOP_R;
        state_next = ALUWB;
      end
      EXEC_I: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALUOP_I;
        state_next = ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      // Target (oldPC+imm from DECODE) goes to PC over the result bus; the
      // link value oldPC+4 equals the already-advanced PC.
      JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      JALR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALUOP_BRANCH;
        result_src = RES_ALUOUT;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = !zero;
          3'b100:  pc_write = !zero;
          3'b101:  pc_write = zero;
          default: pc_write = 1'b0;
        endcase
        state_next = FETCH;
      end
      LUI: begin
        if (opcode == OP_LUI) begin
          alu_src_a  = SRC_A_ZERO;
          alu_src_b  = SRC_B_IMM;
          imm_src    = IMM_JU;
          result_src = RES_ALU;
        end else begin
          result_src = RES_ALUOUT;
        end
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      TRAP: begin
`ifdef SEQ_TRAP_EN
        illegal = 1'b1;
`endif
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    if (reset) begin
      pc_write   = 1'b0;
      adr_src    = ADR_PC;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      imm_src    = IMM_I;
      alu_op     = ALUOP_ADD;
      bus_err    = 1'b0;
      illegal    = 1'b0;
    end
  end

  mc_alu_dec #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_dec (
    .funct3  (funct3),
    .funct7b5(funct7b5),
    .alu_op  (alu_op),
    .alu_ctrl(alu_ctrl)
  );

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: per-cycle expected outputs are queued
// with their stimulus, then drained and compared one cycle at a time.
module tb_mc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_ctrl;
  logic       bus_err, illegal;

  always #5 clk = ~clk;

  mc_sequencer #(
    .ALU_CTRL_W(3),
    .WAIT_MAX  (15),
    .WAIT_CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_req(mem_req),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_ctrl(alu_ctrl), .bus_err(bus_err),
    .illegal(illegal)
  );

  typedef struct packed {
    logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_ctrl;
    logic       bus_err, illegal;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, rdy, rst;
    outs_t      exp, mask;
  } cyc_t;

  cyc_t sb[$];
  int   total = 0;
  int   passed = 0;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011,
                         BAD = 7'b1111111;

  function automatic outs_t o_none();
    outs_t o = '0;
    return o;
  endfunction
  function automatic outs_t o_fw();
    outs_t o = '0;
    o.mem_req = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_fd();
    outs_t o = '0;
    o.pc_write = 1'b1; o.mem_req = 1'b1; o.ir_write = 1'b1;
    o.result_src = 2'b10; o.alu_src_a = 2'b00; o.alu_src_b = 2'b10;
    return o;
  endfunction
  function automatic outs_t o_dec();
    outs_t o = '0;
    o.alu_src_a = 2'b01; o.alu_src_b = 2'b01;
    return o;
  endfunction
  function automatic outs_t o_exec(input logic [1:0] b, input logic [2:0] c);
    outs_t o = '0;
    o.alu_src_a = 2'b10; o.alu_src_b = b; o.alu_ctrl = c;
    return o;
  endfunction
  function automatic outs_t o_wb(input logic [1:0] res);
    outs_t o = '0;
    o.reg_write = 1'b1; o.result_src = res;
    return o;
  endfunction
  function automatic outs_t o_mem(input logic wr);
    outs_t o = '0;
    o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_write = wr;
    return o;
  endfunction
  function automatic outs_t o_br(input logic [2:0] c, input logic pcw);
    outs_t o = '0;
    o.alu_src_a = 2'b10; o.alu_ctrl = c; o.pc_write = pcw;
    return o;
  endfunction
  function automatic outs_t o_jal();
    outs_t o = '0;
    o.pc_write = 1'b1; o.reg_write = 1'b1;
    o.alu_src_a = 2'b01; o.alu_src_b = 2'b10;
    return o;
  endfunction
  function automatic outs_t o_berr();
    outs_t o = '0;
    o.bus_err = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_trap();
    outs_t o = '0;
    o.illegal = 1'b1;
    return o;
  endfunction
  function automatic outs_t m_all();
    outs_t m = '1;
    return m;
  endfunction
  function automatic outs_t m_noimm();
    outs_t m = '1;
    m.imm_src = 2'b00;
    return m;
  endfunction
  function automatic outs_t m_noreq();
    outs_t m = '1;
    m.mem_req = 1'b0;
    return m;
  endfunction

  task automatic push(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic z, input logic rdy, input logic rst,
                      input outs_t e, input outs_t m);
    cyc_t c;
    c.op = op; c.f3 = f3; c.f7 = f7; c.z = z; c.rdy = rdy; c.rst = rst;
    c.exp = e; c.mask = m;
    sb.push_back(c);
  endtask

  task automatic drive(input cyc_t c, output outs_t obs);
    @(negedge clk);
    reset = c.rst; opcode = c.op; funct3 = c.f3; funct7b5 = c.f7;
    zero = c.z; mem_ready = c.rdy;
    #2;
    obs = {pc_write, adr_src, mem_req, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl, bus_err, illegal};
  endtask

  task automatic test_reset();
    cyc_t c; outs_t obs; int n = 0;
    push(RT, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, o_none(), m_noreq());
    push(ST, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, o_none(), m_noreq());
    push(RT, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, o_fw(), m_all());
    while (sb.size() > 0) begin
      c = sb.pop_front(); drive(c, obs); total++; n++;
      if ((obs & c.mask) !== (c.exp & c.mask))
        $display("FAIL reset cyc%0d: got %h want %h", n, obs & c.mask, c.exp & c.mask);
      else passed++;
    end
  endtask

  task automatic test_r_type();
    cyc_t c; outs_t obs; int n = 0;
    // add x3,x1,x2 then sub: second fetch proves the 4-cycle return to FETCH
    push(RT, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, o_fd(), m_all());
    push(RT, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, o_dec(), m_noimm());
    push(RT, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, o_exec(2'b00, 3'd0), m_all());
    push(RT, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, o_wb(2'b00), m_all());
    push(RT, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, o_fd(), m_all());
    push(RT, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, o_dec(), m_noimm());
    push(RT, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, o_exec(2'b00, 3'd1), m_all());
    push(RT, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, o_wb(2'b00), m_all());
    while (sb.size() > 0) begin
      c = sb.pop_front(); drive(c, obs); total++; n++;
      if ((obs & c.mask) !== (c.exp & c.mask))
        $display("FAIL r_type cyc%0d: got %h want %h", n, obs & c.mask, c.exp & c.mask);
      else passed++;
    end
  endtask

  task automatic test_bus_err();
    cyc_t c; outs_t obs; int n = 0;
    for (int i = 0; i < 14; i++)
      push(7'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, o_fw(), m_all());
    push(7'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, o_berr(), m_all());
    push(7'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, o_fw(), m_all());
    while (sb.size() > 0) begin
      c = sb.pop_front(); drive(c, obs); total++; n++;
      if ((obs & c.mask) !== (c.exp & c.mask))
        $display("FAIL bus_err cyc%0d: got %h want %h", n, obs & c.mask, c.exp & c.mask);
      else passed++;
    end
  endtask

  task automatic test_load_wait();
    cyc_t c; outs_t obs; int n = 0;
    push(LD, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, o_fd(), m_all());
    push(LD, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, o_dec(), m_noimm());
    push(LD, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, o_exec(2'b01, 3'd0), m_noimm());
    for (int i = 0; i < 3; i++)
      push(LD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, o_mem(1'b0), m_all());
    push(LD, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, o_mem(1'b0), m_all());
    push(LD, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, o_wb(2'b01), m_all());
    push(LD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, o_fw(), m_all());
    while (sb.size() > 0) begin
      c = sb.pop_front(); drive(c, obs); total++; n++;
      if ((obs & c.mask) !== (c.exp & c.mask))
        $display("FAIL load_wait cyc%0d: got %h want %h", n, obs & c.mask, c.exp & c.mask);
      else passed++;
    end
  endtask

  task automatic test_store();
    cyc_t c; outs_t obs; int n = 0;
    push(ST, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, o_fd(), m_all());
    push(ST, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, o_dec(), m_noimm());
    push(ST, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, o_exec(2'b01, 3'd0), m_noimm());
    push(ST, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, o_mem(1'b1), m_all());
    push(ST, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, o_fw(), m_all());
    while (sb.size() > 0) begin
      c = sb.pop_front(); drive(c, obs); total++; n++;
      if ((obs & c.mask) !== (c.exp & c.mask))
        $display("FAIL store cyc%0d: got %h want %h", n, obs & c.mask, c.exp & c.mask);
      else passed++;
    end
  endtask

  task automatic test_i_type();
    cyc_t c; outs_t obs; int n = 0;
    // addi with funct7b5=1 must stay add; srai uses funct7b5 to pick sra
    push(IT, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, o_fd(), m_all());
    push(IT, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, o_dec(), m_noimm());
    push(IT, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, o_exec(2'b01, 3'd0), m_all());
    push(IT, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, o_wb(2'b00), m_all());
    push(IT, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, o_fd(), m_all());
    push(IT, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, o_dec(), m_noimm());
    push(IT, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, o_exec(2'b01, 3'd7), m_all());
    push(IT, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, o_wb(2'b00), m_all());
    while (sb.size() > 0) begin
      c = sb.pop_front(); drive(c, obs); total++; n++;
      if ((obs & c.mask) !== (c.exp & c.mask))
        $display("FAIL i_type cyc%0d: got %h want %h", n, obs & c.mask, c.exp & c.mask);
      else passed++;
    end
  endtask

  task automatic test_branch();
    cyc_t c; outs_t obs; int n = 0;
    logic [2:0] f3s [4] = '{3'b000, 3'b000, 3'b001, 3'b100};
    logic       zs  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       tk  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] ct  [4] = '{3'd1, 3'd1, 3'd1, 3'd5};
    for (int i = 0; i < 4; i++) begin
      push(BR, f3s[i], 1'b0, zs[i], 1'b1, 1'b0, o_fd(), m_all());
      push(BR, f3s[i], 1'b0, zs[i], 1'b1, 1'b0, o_dec(), m_noimm());
      push(BR, f3s[i], 1'b0, zs[i], 1'b1, 1'b0, o_br(ct[i], tk[i]), m_all());
    end
    while (sb.size() > 0) begin
      c = sb.pop_front(); drive(c, obs); total++; n++;
      if ((obs & c.mask) !== (c.exp & c.mask))
        $display("FAIL branch cyc%0d: got %h want %h", n, obs & c.mask, c.exp & c.mask);
      else passed++;
    end
  endtask

  task automatic test_jal();
    cyc_t c; outs_t obs; int n = 0;
    push(JL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, o_fd(), m_all());
    push(JL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, o_dec(), m_noimm());
    push(JL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, o_jal(), m_all());
    push(JL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, o_fw(), m_all());
    while (sb.size() > 0) begin
      c = sb.pop_front(); drive(c, obs); total++; n++;
      if ((obs & c.mask) !== (c.exp & c.mask))
        $display("FAIL jal cyc%0d: got %h want %h", n, obs & c.mask, c.exp & c.mask);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    cyc_t c; outs_t obs; int n = 0;
    push(BAD, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, o_fd(), m_all());
    push(BAD, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, o_dec(), m_noimm());
`ifdef SEQ_TRAP_EN
    push(BAD, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, o_trap(), m_all());
`endif
    push(BAD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, o_fw(), m_all());
    push(BAD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, o_fw(), m_all());
    while (sb.size() > 0) begin
      c = sb.pop_front(); drive(c, obs); total++; n++;
      if ((obs & c.mask) !== (c.exp & c.mask))
        $display("FAIL illegal cyc%0d: got %h want %h", n, obs & c.mask, c.exp & c.mask);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    cyc_t c; outs_t obs; int n = 0;
    push(ST, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, o_fd(), m_all());
    push(ST, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, o_dec(), m_noimm());
    push(ST, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, o_exec(2'b01, 3'd0), m_noimm());
    push(ST, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, o_mem(1'b1), m_all());
    push(ST, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, o_mem(1'b1), m_all());
    push(ST, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, o_none(), m_noreq());
    push(ST, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, o_fw(), m_all());
    push(ST, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, o_fw(), m_all());
    while (sb.size() > 0) begin
      c = sb.pop_front(); drive(c, obs); total++; n++;
      if ((obs & c.mask) !== (c.exp & c.mask))
        $display("FAIL reset_mid cyc%0d: got %h want %h", n, obs & c.mask, c.exp & c.mask);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_bus_err();
    test_load_wait();
    test_store();
    test_i_type();
    test_branch();
    test_jal();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
